jtag_debug_scan_master: RTL and testbench
=========================================

Name: jtag_debug_scan_master

Overview:
- Host-side scan engine for the Nios II debug slave's virtual-JTAG interface.
- Accepts parallel IR/DR scan commands on a valid/ready port and generates the matching tck, tdi, ir_in and virtual-state strobes (uir, cdr, sdr, udr).
- Samples the slave's tdo and ir_out and returns the captured DR as a response.
- Used as an on-chip debug master and as the simulation driver that replaces the vendor JTAG hub.

Parameters:
- DR_WIDTH, 38: scan chain length in bits (matches the debug slave's sr/jdo width).
- IR_WIDTH, 2: virtual IR width.
- TCK_DIV, 2: tck half-period in clk cycles; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_ir  in  IR_WIDTH  virtual IR value for this scan
- cmd_dr  in  DR_WIDTH  data shifted into the slave, LSB first
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_dr  out  DR_WIDTH  data shifted out of the slave; bit0 is the first bit captured
- rsp_ir_out  out  IR_WIDTH  ir_out sampled at the end of CDR
- tck  out  1  generated JTAG clock
- tdi  out  1  serial data to the slave
- tdo  in  1  serial data from the slave
- ir_in  out  IR_WIDTH  virtual IR presented to the slave
- ir_out  in  IR_WIDTH  slave IR status
- jtag_state_rti  out  1  high while idle
- vs_uir, vs_cdr, vs_sdr, vs_udr  out  1 each  virtual-state strobes
- busy  out  1  high from command accept until the end of UDR

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_dr=0, rsp_ir_out=0, tck=0, tdi=0, ir_in=0, jtag_state_rti=1, all vs_*=0, busy=0.
- Reset mid-scan: the in-flight command is dropped, no response is produced, and all outputs return to their reset values on the next clk.
- FSM states: IDLE -> UIR -> CDR -> SHIFT -> UDR -> RESP -> IDLE.
- tck period: each state occupies whole tck periods of 2*TCK_DIV clk cycles.
  - tck is 0 for the first TCK_DIV cycles of a period and 1 for the last TCK_DIV cycles.
  - tdi and the vs_* strobes change only at period start.
  - tdo and ir_out are sampled on the clk cycle in which tck goes 0->1.
- IDLE:
  - cmd_ready = !rsp_valid.
  - On cmd_valid & cmd_ready: latch cmd_ir and cmd_dr, set busy=1, drop jtag_state_rti, go to UIR on the next clk.
- UIR (1 period): ir_in = latched IR, held stable until the next accepted command; vs_uir=1.
- CDR (1 period): vs_cdr=1; ir_out sampled into rsp_ir_out at the rising tck.
- SHIFT (DR_WIDTH periods): vs_sdr=1.
  - tdi = dr[k] in period k (k = 0..DR_WIDTH-1).
  - tdo sampled in period k is stored in capture[k].
- UDR (1 period): vs_udr=1, tdi=0.
  - At the end of the period: rsp_dr <= capture, rsp_valid=1, busy=0, state RESP.
- RESP: hold rsp_valid until rsp_ready, then go to IDLE with jtag_state_rti=1.
  - rsp_valid and rsp_ready high in the same cycle: the response clears on that clk.
  - A new command can be accepted on the following clk.
- Latency: a command accepted at cycle 0 gives rsp_valid at cycle 1 + (DR_WIDTH+3)*2*TCK_DIV; for the defaults this is cycle 165.
- Only one command is outstanding at a time. cmd_valid is ignored while busy or while rsp_valid is high.
- The tck/period counter wraps at 2*TCK_DIV-1. The bit counter terminates exactly at DR_WIDTH-1, with no off-by-one extra period.

Optional Feature:
- Macro: JTAG_DEBUG_SCAN_IR_CACHE_EN.
- Defined:
  - The engine keeps the last IR loaded; it resets to 0.
  - If cmd_ir equals that value, UIR is skipped (IDLE -> CDR) and latency drops by one tck period; for the defaults, rsp_valid comes at cycle 161.
  - After reset the first command always runs UIR.
- Undefined: UIR runs for every command.

Test Plan:
- Loopback (tdo tied to tdi), cmd_ir=2'b01, cmd_dr=38'h2A_5555_5555 -> rsp_dr=38'h2A_5555_5555; ir_in=2'b01 from the UIR period on; rsp_valid exactly at cycle 165.
- tdo held 1, ir_out=2'b10 -> rsp_dr=38'h3F_FFFF_FFFF, rsp_ir_out=2'b10.
- Strobe sequence check: exactly one 4-clk vs_uir pulse, one vs_cdr, 38 periods of vs_sdr, one vs_udr, in that order; tck has exactly 41 rising edges per command.
- Backpressure: hold rsp_ready=0 for 20 cycles with cmd_valid=1 -> cmd_ready stays 0 and no second scan starts; after rsp_ready the second command is accepted 1 clk later.
- Reset asserted during SHIFT bit 10 -> next clk all outputs are at their reset values, rsp_valid never asserts, a fresh command then completes normally.
- With JTAG_DEBUG_SCAN_IR_CACHE_EN, two back-to-back commands with ir=2'b10: the first has a vs_uir pulse and rsp at cycle 165; the second has no vs_uir and rsp at cycle 161.

Source files
------------

// File: rtl/jtag_debug_scan_master.sv
// jtag_debug_scan_master
//
// Host-side scan engine for a virtual-JTAG debug slave. It takes one parallel
// IR/DR scan command at a time and plays it out serially as UIR -> CDR ->
// SHIFT -> UDR, with one tck period per state and DR_WIDTH periods in SHIFT.
// It then returns the captured DR and the IR status sampled during CDR.
//
// Every tck period lasts 2*TCK_DIV clk cycles. tck is low for the first half
// and high for the second half. tdi and the vs_* strobes change only when a
// period starts. tdo and ir_out are sampled on the clk edge that raises tck.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake, with cmd_ir / cmd_dr payload
//   rsp_valid/rsp_ready     response handshake, with rsp_dr / rsp_ir_out
//   tck, tdi, tdo           serial scan interface to the slave
//   ir_in, ir_out           virtual IR presented to the slave / slave status
//   jtag_state_rti          high while the engine is idle
//   vs_uir/cdr/sdr/udr      virtual-state strobes, one per scan phase
//   busy                    high from command accept until the end of UDR
//
// Optional build macro
//   JTAG_DEBUG_SCAN_IR_CACHE_EN : skip the UIR period when the new command's
//   IR equals the IR that is already loaded. After reset the first command
//   always loads its IR.

module jtag_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                jtag_state_rti,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_UIR   = 3'd1;
    localparam logic [2:0] S_CDR   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_UDR   = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    // 9 bits covers a full period at the largest divider (2*255-1)
    localparam int                PH_W     = 9;
    localparam logic [PH_W-1:0]   PH_RISE  = PH_W'(TCK_DIV - 1);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(2 * TCK_DIV - 1);
    localparam int                BIT_W    = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DR_WIDTH - 1);

    logic [2:0]          state_r;
    logic [PH_W-1:0]     phase_r;
    logic [BIT_W-1:0]    bit_r;
    logic                go_r;
    logic [IR_WIDTH-1:0] ir_r;
    logic [DR_WIDTH-1:0] dr_r;
    logic [DR_WIDTH-1:0] cap_r;
`ifdef JTAG_DEBUG_SCAN_IR_CACHE_EN
    logic                ir_loaded_r;
`endif

    logic scan_s;
    logic rise_s;
    logic period_end_s;
    logic skip_uir_s;

    // Period timing decode and UIR-skip decision
    always_comb begin
        scan_s       = 1'b0;
        rise_s       = 1'b0;
        period_end_s = 1'b0;
        skip_uir_s   = 1'b0;
        if ((state_r == S_UIR) || (state_r == S_CDR) ||
            (state_r == S_SHIFT) || (state_r == S_UDR)) begin
            scan_s = 1'b1;
        end else begin
            scan_s = 1'b0;
        end
        rise_s       = scan_s && (phase_r == PH_RISE);
        period_end_s = scan_s && (phase_r == PH_LAST);
`ifdef JTAG_DEBUG_SCAN_IR_CACHE_EN
        // ir_in already holds the last IR loaded, so it doubles as the cache
        skip_uir_s = ir_loaded_r && (ir_r == ir_in);
`else
        skip_uir_s = 1'b0;
`endif
    end

    // tck phase counter: low half, then high half, restarting at every period
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r <= {PH_W{1'b0}};
            tck     <= 1'b0;
        end else if (scan_s) begin
            if (period_end_s) begin
                phase_r <= {PH_W{1'b0}};
                tck     <= 1'b0;
            end else begin
                phase_r <= phase_r + 9'd1;
                if (rise_s) begin
                    tck <= 1'b1;
                end else begin
                    tck <= tck;
                end
            end
        end else begin
            phase_r <= {PH_W{1'b0}};
            tck     <= 1'b0;
        end
    end

    // Scan sequencer: command latch, strobes, serial data and response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_IDLE;
            bit_r          <= {BIT_W{1'b0}};
            go_r           <= 1'b0;
            ir_r           <= {IR_WIDTH{1'b0}};
            dr_r           <= {DR_WIDTH{1'b0}};
            cap_r          <= {DR_WIDTH{1'b0}};
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_dr         <= {DR_WIDTH{1'b0}};
            rsp_ir_out     <= {IR_WIDTH{1'b0}};
            tdi            <= 1'b0;
            ir_in          <= {IR_WIDTH{1'b0}};
            jtag_state_rti <= 1'b1;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            busy           <= 1'b0;
`ifdef JTAG_DEBUG_SCAN_IR_CACHE_EN
            ir_loaded_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (go_r) begin
                        // One cycle after accept: start the first tck period
                        go_r <= 1'b0;
                        if (skip_uir_s) begin
                            state_r <= S_CDR;
                            vs_cdr  <= 1'b1;
                        end else begin
                            state_r <= S_UIR;
                            vs_uir  <= 1'b1;
                            ir_in   <= ir_r;
                        end
`ifdef JTAG_DEBUG_SCAN_IR_CACHE_EN
                        ir_loaded_r <= 1'b1;
`endif
                    end else if (cmd_valid && cmd_ready) begin
                        ir_r           <= cmd_ir;
                        dr_r           <= cmd_dr;
                        busy           <= 1'b1;
                        jtag_state_rti <= 1'b0;
                        cmd_ready      <= 1'b0;
                        go_r           <= 1'b1;
                    end else begin
                        cmd_ready <= !rsp_valid;
                    end
                end
                S_UIR: begin
                    if (period_end_s) begin
                        state_r <= S_CDR;
                        vs_uir  <= 1'b0;
                        vs_cdr  <= 1'b1;
                    end
                end
                S_CDR: begin
                    if (rise_s) begin
                        rsp_ir_out <= ir_out;
                    end
                    if (period_end_s) begin
                        state_r <= S_SHIFT;
                        vs_cdr  <= 1'b0;
                        vs_sdr  <= 1'b1;
                        bit_r   <= {BIT_W{1'b0}};
                        tdi     <= dr_r[0];
                        dr_r    <= {1'b0, dr_r[DR_WIDTH-1:1]};
                    end
                end
                S_SHIFT: begin
                    // First captured bit ends up in bit 0 after DR_WIDTH shifts
                    if (rise_s) begin
                        cap_r <= {tdo, cap_r[DR_WIDTH-1:1]};
                    end
                    if (period_end_s) begin
                        if (bit_r == BIT_LAST) begin
                            state_r <= S_UDR;
                            vs_sdr  <= 1'b0;
                            vs_udr  <= 1'b1;
                            tdi     <= 1'b0;
                        end else begin
                            bit_r <= bit_r + BIT_W'(1);
                            tdi   <= dr_r[0];
                            dr_r  <= {1'b0, dr_r[DR_WIDTH-1:1]};
                        end
                    end
                end
                S_UDR: begin
                    if (period_end_s) begin
                        state_r   <= S_RESP;
                        vs_udr    <= 1'b0;
                        rsp_dr    <= cap_r;
                        rsp_valid <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_r        <= S_IDLE;
                        rsp_valid      <= 1'b0;
                        jtag_state_rti <= 1'b1;
                        cmd_ready      <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_debug_scan_master.sv
// Directed bench for jtag_debug_scan_master: loopback and constant-tdo scans,
// strobe ordering, response backpressure, reset during SHIFT and IR caching.
module tb_jtag_debug_scan_master;

    localparam int DR_W      = 38;
    localparam int IR_W      = 2;
    localparam int TD        = 2;
    localparam int PER       = 2 * TD;
    localparam int LAT_FULL  = 1 + (DR_W + 3) * PER;
    localparam int LAT_SKIP  = 1 + (DR_W + 2) * PER;
`ifdef JTAG_DEBUG_SCAN_IR_CACHE_EN
    localparam bit CACHE_EN  = 1'b1;
`else
    localparam bit CACHE_EN  = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_dr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DR_W-1:0] rsp_dr;
    logic [IR_W-1:0] rsp_ir_out;
    logic            tck;
    logic            tdi;
    logic            tdo;
    logic [IR_W-1:0] ir_in;
    logic [IR_W-1:0] ir_out;
    logic            jtag_state_rti;
    logic            vs_uir, vs_cdr, vs_sdr, vs_udr;
    logic            busy;

    logic            loop_mode;
    logic            tdo_val;

    assign tdo = loop_mode ? tdi : tdo_val;

    jtag_debug_scan_master #(.DR_WIDTH(DR_W), .IR_WIDTH(IR_W), .TCK_DIV(TD)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
        .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
        .jtag_state_rti(jtag_state_rti),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe / tck activity monitor, cleared before each scan
    logic mon_clr = 1'b0;
    int   uir_cyc, cdr_cyc, sdr_cyc, udr_cyc, uir_pulses, tck_rises, order_err, last_rank;
    logic prev_tck, prev_uir;
    always @(posedge clk) begin
        if (mon_clr) begin
            uir_cyc <= 0; cdr_cyc <= 0; sdr_cyc <= 0; udr_cyc <= 0;
            uir_pulses <= 0; tck_rises <= 0; order_err <= 0; last_rank <= 0;
        end else begin
            if (vs_uir) uir_cyc <= uir_cyc + 1;
            if (vs_cdr) cdr_cyc <= cdr_cyc + 1;
            if (vs_sdr) sdr_cyc <= sdr_cyc + 1;
            if (vs_udr) udr_cyc <= udr_cyc + 1;
            if (vs_uir && !prev_uir) uir_pulses <= uir_pulses + 1;
            if (tck && !prev_tck) tck_rises <= tck_rises + 1;
            if ((32'(vs_uir) + 32'(vs_cdr) + 32'(vs_sdr) + 32'(vs_udr)) > 1) begin
                order_err <= order_err + 1;
            end else if (vs_uir || vs_cdr || vs_sdr || vs_udr) begin
                if ((vs_uir ? 1 : vs_cdr ? 2 : vs_sdr ? 3 : 4) < last_rank)
                    order_err <= order_err + 1;
                last_rank <= vs_uir ? 1 : vs_cdr ? 2 : vs_sdr ? 3 : 4;
            end
        end
        prev_tck <= tck;
        prev_uir <= vs_uir;
    end

    int tests = 0;
    int fails = 0;

    // Scoreboard and reference IR-cache model
    logic [DR_W-1:0] exp_dr_q[$];
    logic [IR_W-1:0] exp_ir_q[$];
    int              exp_lat_q[$];
    int              accept_cyc;
    logic [IR_W-1:0] cur_ir;
    bit              cur_skip;
    bit              model_valid = 1'b0;
    logic [IR_W-1:0] model_ir = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_hs"}, 64'({cmd_ready, rsp_valid, busy, jtag_state_rti}), 64'(4'b1001));
        chk({tag, "_pins"}, 64'({tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_udr}), 64'(6'b000000));
        chk({tag, "_ir_in"}, 64'(ir_in), 64'(0));
        chk({tag, "_rsp_ir"}, 64'(rsp_ir_out), 64'(0));
        chk({tag, "_rsp_dr"}, 64'(rsp_dr), 64'(0));
    endtask

    // Called right after the edge on which the DUT took the command
    task automatic record_accept(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] exp_dr);
        accept_cyc = cyc;
        cur_ir     = ir;
        cur_skip   = CACHE_EN && model_valid && (ir == model_ir);
        model_valid = 1'b1;
        model_ir    = ir;
        exp_dr_q.push_back(exp_dr);
        exp_ir_q.push_back(ir_out);
        exp_lat_q.push_back(cur_skip ? LAT_SKIP : LAT_FULL);
    endtask

    task automatic send(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                        input logic [DR_W-1:0] exp_dr);
        int n;
        cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin step(); n++; end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        step();
        record_accept(ir, exp_dr);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        bit saw;
        n = 0; saw = 1'b0;
        while (!rsp_valid && n < 1000) begin
            if (vs_uir && !saw) begin
                saw = 1'b1;
                chk("ir_in_at_uir", 64'(ir_in), 64'(cur_ir));
            end
            step(); n++;
        end
        chk("rsp_valid_wait", 64'(rsp_valid), 64'(1));
        if (rsp_valid && exp_dr_q.size() > 0) begin
            chk("latency", 64'(cyc - accept_cyc), 64'(exp_lat_q.pop_front()));
            chk("rsp_dr", 64'(rsp_dr), 64'(exp_dr_q.pop_front()));
            chk("rsp_ir_out", 64'(rsp_ir_out), 64'(exp_ir_q.pop_front()));
        end else if (rsp_valid) begin
            chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_cleared", 64'({rsp_valid, cmd_ready, jtag_state_rti}), 64'(3'b011));
    endtask

    task automatic do_scan(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                           input logic [DR_W-1:0] exp_dr);
        int u;
        mon_clr = 1'b1; step(); mon_clr = 1'b0;
        send(ir, dr, exp_dr);
        wait_rsp();
        consume();
        u = cur_skip ? 0 : 1;
        chk("uir_pulses", 64'(uir_pulses), 64'(u));
        chk("uir_cycles", 64'(uir_cyc), 64'(u * PER));
        chk("cdr_cycles", 64'(cdr_cyc), 64'(PER));
        chk("sdr_cycles", 64'(sdr_cyc), 64'(DR_W * PER));
        chk("udr_cycles", 64'(udr_cyc), 64'(PER));
        chk("tck_rises", 64'(tck_rises), 64'(DR_W + 2 + u));
        chk("strobe_order", 64'(order_err), 64'(0));
    endtask

    initial begin
        logic [DR_W-1:0] d;
        logic [DR_W-1:0] ones;
        int bad;
        int n;

        reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0;
        rsp_ready = 1'b0; ir_out = '0; loop_mode = 1'b1; tdo_val = 1'b0;
        repeat (3) step();
        check_reset("por");
        reset = 1'b0;
        step();

        // Loopback with the reference pattern
        ir_out = 2'b01;
        d = 38'h2A_5555_5555;
        do_scan(2'b01, d, d);
        chk("ir_in_held", 64'(ir_in), 64'(2'b01));

        // tdo stuck high, distinct ir_out
        loop_mode = 1'b0; tdo_val = 1'b1; ir_out = 2'b10;
        ones = '1;
        do_scan(2'b01, 38'h01_2345_6789, ones);
        loop_mode = 1'b1;

        // Response backpressure with a second command waiting
        ir_out = 2'b11;
        d = {6'($urandom), 32'($urandom)};
        send(2'b11, d, d);
        wait_rsp();
        d = {6'($urandom), 32'($urandom)};
        cmd_ir = 2'b01; cmd_dr = d; cmd_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            step();
            if (cmd_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b1 ||
                tck !== 1'b0 || vs_uir !== 1'b0 || vs_cdr !== 1'b0)
                bad++;
        end
        chk("backpressure_hold", 64'(bad), 64'(0));
        consume();
        step();
        record_accept(2'b01, d);
        cmd_valid = 1'b0;
        chk("second_accept", 64'({busy, cmd_ready, jtag_state_rti}), 64'(3'b100));
        wait_rsp();
        consume();

        // Reset in the middle of SHIFT bit 10
        d = {6'($urandom), 32'($urandom)};
        send(2'b10, d, d);
        n = 0;
        while (!vs_sdr && n < 1000) begin step(); n++; end
        repeat (42) step();
        chk("sdr_before_reset", 64'(vs_sdr), 64'(1));
        reset = 1'b1;
        step();
        check_reset("mid");
        reset = 1'b0;
        exp_dr_q.delete(); exp_ir_q.delete(); exp_lat_q.delete();
        model_valid = 1'b0; model_ir = '0;
        bad = 0;
        repeat (200) begin
            step();
            if (rsp_valid !== 1'b0) bad++;
        end
        chk("no_rsp_after_reset", 64'(bad), 64'(0));
        d = {6'($urandom), 32'($urandom)};
        do_scan(2'b11, d, d);

        // Back-to-back commands with the same IR
        ir_out = 2'b01;
        d = {6'($urandom), 32'($urandom)};
        do_scan(2'b10, d, d);
        d = {6'($urandom), 32'($urandom)};
        do_scan(2'b10, d, d);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
